mem_pwm: RTL and testbench

MEM_PWM -- requirements
Module: mem_pwm

---
 rtl/mem_pwm_if.sv | 28 ++
 rtl/mem_pwm.sv | 182 ++++++++++++++++++
 tb/tb_mem_pwm.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pwm_if.sv
// mem_pwm bus interface: simple valid/ready memory port.
// The host drives the master side, the PWM block is the slave.
interface mem_pwm_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/mem_pwm.sv
// mem_pwm: multi-channel PWM with prescaler and shadowed registers.
// Shadow PERIOD/DUTY load into the active set at wrap or while stopped.
module mem_pwm #(
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_pwm_if.slave            bus,
  output logic [CHANNELS-1:0] pwm_oe,
  output logic [CHANNELS-1:0] pwm_do,
  output logic                irq
);

  // bus handshake and read path
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd;

  // control fields
  logic        en_q, en_d;
  logic        ien_q, ien_d;
  logic [7:0]  oe_q, oe_d;
  logic [15:0] psc_q, psc_d;

  // shadow and active timing registers (8 slots, CHANNELS used)
  logic [15:0] per_sh_q, per_sh_d;
  logic [15:0] per_act_q, per_act_d;
  logic [15:0] duty_sh_q [8];
  logic [15:0] duty_sh_d [8];
  logic [15:0] duty_act_q [8];
  logic [15:0] duty_act_d [8];

  // counters and status
  logic [15:0] pre_q, pre_d;
  logic [15:0] cnt_q, cnt_d;
  logic        wrap_q, wrap_d;
  logic [CHANNELS-1:0] do_q, do_d;
  logic        irq_q, irq_d;

  // decode
  logic        acc, wr;
  logic [3:0]  idx;
  logic [3:0]  dn;
  logic        sel_ctrl, sel_per, sel_cnt;
  logic        sel_stat, sel_duty;
  logic        clr, tick, wrap, load;
  logic        unused;

  assign acc = bus.mem_valid && !ready_q;
  assign wr  = acc && (bus.mem_wstrb == 4'hF);
  assign idx = bus.mem_addr[5:2];
  assign dn  = idx - 4'd4;

  assign sel_ctrl = (idx == 4'd0);
  assign sel_per  = (idx == 4'd1);
  assign sel_cnt  = (idx == 4'd2);
  assign sel_stat = (idx == 4'd3);
  assign sel_duty = (idx >= 4'd4) && (32'(dn) < CHANNELS);

  // CLR wins over a tick and suppresses the wrap in that cycle
  assign clr  = wr && sel_ctrl && bus.mem_wdata[1];
  assign tick = en_q && (pre_q == psc_q);
  assign wrap = tick && !clr && (cnt_q == per_act_q);
  assign load = !en_q || wrap;

  assign unused = ^{bus.mem_addr[31:6], bus.mem_addr[1:0],
                    bus.mem_wdata[7:3], dn[3]};

  // read mux: shadow values are what software sees
  always_comb begin
    rd = '0;
    unique case (1'b1)
      sel_ctrl: rd = {psc_q, oe_q, 5'b0, ien_q, 1'b0, en_q};
      sel_per:  rd = {16'h0, per_sh_q};
      sel_cnt:  rd = {16'h0, cnt_q};
      sel_stat: rd = {31'h0, wrap_q};
      sel_duty: rd = {16'h0, duty_sh_q[dn[2:0]]};
      default:  rd = '0;
    endcase
  end

  // register writes, counters, shadow loads and outputs
  always_comb begin
    ready_d    = acc;
    rdata_d    = acc ? rd : rdata_q;
    en_d       = en_q;
    ien_d      = ien_q;
    oe_d       = oe_q;
    psc_d      = psc_q;
    per_sh_d   = per_sh_q;
    duty_sh_d  = duty_sh_q;
    per_act_d  = per_act_q;
    duty_act_d = duty_act_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    wrap_d     = wrap_q;
    do_d       = '0;
    irq_d      = wrap_q && ien_q;

    if (wr && sel_ctrl) begin
      en_d  = bus.mem_wdata[0];
      ien_d = bus.mem_wdata[2];
      oe_d  = bus.mem_wdata[15:8];
      psc_d = bus.mem_wdata[31:16];
    end
    if (wr && sel_per) begin
      per_sh_d = bus.mem_wdata[15:0];
    end
    if (wr && sel_duty) begin
      duty_sh_d[dn[2:0]] = bus.mem_wdata[15:0];
    end

    if (load) begin
      per_act_d  = per_sh_q;
      duty_act_d = duty_sh_q;
    end

    if (clr) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (en_q) begin
      pre_d = tick ? 16'd0 : pre_q + 16'd1;
      if (tick) begin
        cnt_d = (cnt_q == per_act_q) ? 16'd0 : cnt_q + 16'd1;
      end
    end

    if (wrap) begin
      wrap_d = 1'b1;
    end else if (wr && sel_stat && bus.mem_wdata[0]) begin
      wrap_d = 1'b0;
    end

    for (int n = 0; n < CHANNELS; n++) begin
      do_d[n] = en_q && (cnt_q < duty_act_q[n]);
    end
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      en_q       <= 1'b0;
      ien_q      <= 1'b0;
      oe_q       <= '0;
      psc_q      <= '0;
      per_sh_q   <= '0;
      per_act_q  <= '0;
      duty_sh_q  <= '{default: '0};
      duty_act_q <= '{default: '0};
      pre_q      <= '0;
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      do_q       <= '0;
      irq_q      <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      en_q       <= en_d;
      ien_q      <= ien_d;
      oe_q       <= oe_d;
      psc_q      <= psc_d;
      per_sh_q   <= per_sh_d;
      per_act_q  <= per_act_d;
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      do_q       <= do_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign pwm_oe        = oe_q[CHANNELS-1:0];
  assign pwm_do        = do_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_mem_pwm.sv
// tb_mem_pwm: scoreboard bench for mem_pwm.
// Bus reads queue expected data; a monitor checks on mem_ready.
module tb_mem_pwm;

  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_PER  = 32'h04;
  localparam logic [31:0] A_CNT  = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C;
  localparam logic [31:0] A_D0   = 32'h10;
  localparam logic [31:0] A_D7   = 32'h2C;
  localparam logic [31:0] A_UNM  = 32'h30;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    bit          chk;
    string       name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] pwm_oe;
  logic [3:0] pwm_do;
  logic       irq;

  int   checks;
  int   failures;
  exp_t sbq[$];
  logic ready_prev;

  mem_pwm_if bus ();

  mem_pwm #(.CHANNELS(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pwm_oe (pwm_oe),
    .pwm_do (pwm_do),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: pop one expectation per completion pulse
  always @(negedge clk) begin
    exp_t x;
    if (bus.mem_ready) begin
      if (ready_prev === 1'b1) begin
        failures++;
        $display("FAIL ready_pulse act=two-cycle req=one-cycle");
      end
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL spurious_ready act=1 req=0");
      end else begin
        x = sbq.pop_front();
        if (x.chk) begin
          checks++;
          if ((bus.mem_rdata & x.mask) !== x.exp) begin
            failures++;
            $display("FAIL %s act=%h req=%h", x.name,
                     bus.mem_rdata & x.mask, x.exp);
          end
        end
      end
    end
    ready_prev <= bus.mem_ready;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h req=%h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit c,
                      input logic [31:0] e, input logic [31:0] m,
                      input string nm);
    exp_t x;
    bit   done;
    x.exp = e; x.mask = m; x.chk = c; x.name = nm;
    sbq.push_back(x);
    @(posedge clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_wstrb = s;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk); #1;
      if (bus.mem_ready) done = 1'b1;
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout act=no-ready req=ready", nm);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xfer(a, d, 4'hF, 1'b0, 32'h0, 32'h0, "wr");
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e,
                    input string nm);
    xfer(a, 32'h0, 4'h0, 1'b1, e, 32'hFFFF_FFFF, nm);
  endtask

  task automatic wait_rise();
    logic p;
    bit   found;
    found = 1'b0;
    p = pwm_do[0];
    for (int t = 0; t < 200 && !found; t++) begin
      @(posedge clk); #1;
      if (!p && pwm_do[0]) found = 1'b1;
      p = pwm_do[0];
    end
    if (!found) begin
      failures++;
      $display("FAIL rise_timeout act=none req=edge");
    end
  endtask

  task automatic measure(output int hi, output int lo);
    bit go;
    wait_rise();
    hi = 1; lo = 0; go = 1'b1;
    while (go && hi < 200) begin
      @(posedge clk); #1;
      if (pwm_do[0]) hi++;
      else go = 1'b0;
    end
    lo = 1; go = 1'b1;
    while (go && lo < 200) begin
      @(posedge clk); #1;
      if (!pwm_do[0]) lo++;
      else go = 1'b0;
    end
  endtask

  task automatic count_hi(input int n, output int h);
    h = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (pwm_do[0]) h++;
    end
  endtask

  initial begin
    int hi, lo, h, rp;
    checks = 0; failures = 0;
    ready_prev = 1'b0;
    rst = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    #1;
    chk("rst_ready", 32'(bus.mem_ready), 32'h0);
    chk("rst_rdata", bus.mem_rdata, 32'h0);
    chk("rst_do", 32'(pwm_do), 32'h0);
    chk("rst_oe", 32'(pwm_oe), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // basic waveform: period 10, 3 high
    wr(A_PER, 32'd9);
    wr(A_D0, 32'd3);
    wr(A_CTRL, 32'h0000_0103);
    chk("oe_mask", 32'(pwm_oe), 32'h1);
    rd(A_CTRL, 32'h0000_0101, "ctrl_clr_reads0");
    measure(hi, lo);
    chk("p9_hi", hi, 3);
    chk("p9_lo", lo, 7);
    rd(A_STAT, 32'h1, "wrap_set");

    // stop, clear, W1C, then prescaled run
    wr(A_CTRL, 32'h2);
    rd(A_CNT, 32'h0, "cnt_after_clr");
    wr(A_STAT, 32'h1);
    rd(A_STAT, 32'h0, "wrap_w1c");
    wr(A_PER, 32'd1);
    wr(A_D0, 32'd1);
    wr(A_CTRL, 32'h0004_0101);
    measure(hi, lo);
    chk("psc_hi", hi, 5);
    chk("psc_lo", lo, 5);
    for (int k = 0; k < 3; k++) begin
      xfer(A_CNT, 32'h0, 4'h0, 1'b1, 32'h0,
           32'hFFFF_FFFE, "cnt_le1");
      repeat (k + 1) @(posedge clk);
    end

    // duty change mid-period waits for the wrap
    wr(A_CTRL, 32'h2);
    wr(A_PER, 32'd9);
    wr(A_D0, 32'd3);
    wr(A_CTRL, 32'h0000_0101);
    wr(A_D0, 32'd8);
    repeat (4) @(posedge clk);
    #1;
    chk("old_duty_holds", 32'(pwm_do[0]), 32'h0);
    rd(A_D0, 32'd8, "duty_shadow_rd");
    measure(hi, lo);
    chk("new_duty_hi", hi, 8);
    chk("new_duty_lo", lo, 2);

    // constant low / high and unmapped slots
    wr(A_D0, 32'd0);
    repeat (15) @(posedge clk);
    count_hi(20, h);
    chk("duty0_low", h, 0);
    wr(A_D0, 32'd20);
    repeat (15) @(posedge clk);
    count_hi(20, h);
    chk("duty20_high", h, 20);
    wr(A_D7, 32'h1234);
    rd(A_D7, 32'h0, "duty7_unmapped");
    rd(A_UNM, 32'h0, "unmapped_rd");
    wr(A_PER, 32'hFFFF_0009);
    rd(A_PER, 32'h9, "per_upper_drop");

    // interrupt and W1C racing a wrap
    wr(A_CTRL, 32'h2);
    wr(A_D0, 32'd3);
    wr(A_STAT, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("irq_clear", 32'(irq), 32'h0);
    wr(A_CTRL, 32'h0000_0105);
    repeat (25) @(posedge clk);
    #1;
    chk("irq_set", 32'(irq), 32'h1);
    wait_rise();
    wr(A_STAT, 32'h1);
    rd(A_STAT, 32'h0, "w1c_off_wrap");
    chk("irq_drop", 32'(irq), 32'h0);
    wait_rise();
    repeat (7) @(posedge clk);
    wr(A_STAT, 32'h1);
    rd(A_STAT, 32'h1, "w1c_on_wrap");
    chk("irq_hold", 32'(irq), 32'h1);

    // partial strobe is a read
    xfer(A_PER, 32'd5, 4'h3, 1'b1, 32'h9,
         32'hFFFF_FFFF, "partial_rd");
    rd(A_PER, 32'h9, "partial_no_wr");

    // asynchronous reset mid-run
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_do", 32'(pwm_do), 32'h0);
    chk("mid_rst_oe", 32'(pwm_oe), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_rdata", bus.mem_rdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // reset aborts a pending request
    @(posedge clk); #1;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = A_PER;
    bus.mem_wstrb = 4'h0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    rst = 1'b0;
    rp = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.mem_ready) rp++;
    end
    chk("abort_no_ready", rp, 0);
    rd(A_CTRL, 32'h0, "ctrl_after_rst");
    rd(A_PER, 32'h0, "per_after_rst");

    for (int t = 0; t < 20 && sbq.size() != 0; t++) begin
      @(posedge clk);
    end
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain act=%0d req=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
